// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD combinational read ports and two write ports.
// Optional write-to-read bypass and optional hardwired-zero entry 0.
// i_clr starts a clear sweep that zeroes one entry per cycle.
// Port 1 wins a same-address write collision, both on store and on bypass.

// Per-read-port mux: stored value, optional bypass, optional zero entry
module regfile_mp_rd #(
    parameter int BW_DATA  = 16,
    parameter int BW_ADDR  = 4,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  logic [BW_ADDR-1:0] rd_addr,
    input  logic [BW_DATA-1:0] stored,
    input  logic               byp_en,
    input  logic               wr_en0,
    input  logic [BW_ADDR-1:0] wr_addr0,
    input  logic [BW_DATA-1:0] wr_data0,
    input  logic               wr_en1,
    input  logic [BW_ADDR-1:0] wr_addr1,
    input  logic [BW_DATA-1:0] wr_data1,
    output logic [BW_DATA-1:0] rd_data
);
    // port 1 is checked last so it wins on collision; zero entry overrides everything
    always_comb begin
        rd_data = stored;
        if (BYPASS != 0 && byp_en) begin
            if (wr_en0 && wr_addr0 == rd_addr) rd_data = wr_data0;
            if (wr_en1 && wr_addr1 == rd_addr) rd_data = wr_data1;
        end
        if (ZERO_REG != 0 && rd_addr == '0) rd_data = '0;
    end
endmodule

module regfile_mp #(
    parameter int BW_DATA  = 16,
    parameter int BW_ADDR  = 4,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_clr,
    output logic                      o_busy,
    input  logic                      i_wr_en0,
    input  logic [BW_ADDR-1:0]        i_wr_addr0,
    input  logic [BW_DATA-1:0]        i_wr_data0,
    input  logic                      i_wr_en1,
    input  logic [BW_ADDR-1:0]        i_wr_addr1,
    input  logic [BW_DATA-1:0]        i_wr_data1,
    input  logic [NUM_RD*BW_ADDR-1:0] i_rd_addr,
    output logic [NUM_RD*BW_DATA-1:0] o_rd_data
);
    localparam int DEPTH = 2 ** BW_ADDR;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                              state;
    logic   [BW_ADDR-1:0]                cnt;
    logic   [BW_DATA-1:0]                mem [DEPTH];
    logic                                idle;
    logic                                wr_ok0, wr_ok1;
    logic   [NUM_RD-1:0][BW_ADDR-1:0]    rd_addr_a;
    logic   [NUM_RD-1:0][BW_DATA-1:0]    rd_data_a;
    logic   [NUM_RD-1:0][BW_DATA-1:0]    stored_a;

    assign idle = (state == IDLE);

    // writes only land while idle; the zero entry silently drops them
    assign wr_ok0 = i_wr_en0 && idle && !(ZERO_REG != 0 && i_wr_addr0 == '0);
    assign wr_ok1 = i_wr_en1 && idle && !(ZERO_REG != 0 && i_wr_addr1 == '0);

    // sweep sequencer: o_busy is registered alongside the state
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state  <= IDLE;
            cnt    <= '0;
            o_busy <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_clr) begin
                        state  <= CLEAR;
                        cnt    <= '0;
                        o_busy <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (cnt == {BW_ADDR{1'b1}}) begin
                        state  <= IDLE;
                        cnt    <= '0;
                        o_busy <= 1'b0;
                    end else begin
                        cnt <= cnt + BW_ADDR'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    cnt    <= '0;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

    // storage: sweep zeroes entry[cnt]; otherwise port 0 then port 1 so port 1 wins
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (!idle) begin
            mem[cnt] <= '0;
        end else begin
            if (wr_ok0) mem[i_wr_addr0] <= i_wr_data0;
            if (wr_ok1) mem[i_wr_addr1] <= i_wr_data1;
        end
    end

    assign rd_addr_a = i_rd_addr;
    assign o_rd_data = rd_data_a;

    // one read mux per port
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        assign stored_a[k] = mem[rd_addr_a[k]];

        regfile_mp_rd #(
            .BW_DATA (BW_DATA),
            .BW_ADDR (BW_ADDR),
            .BYPASS  (BYPASS),
            .ZERO_REG(ZERO_REG)
        ) u_rd (
            .rd_addr (rd_addr_a[k]),
            .stored  (stored_a[k]),
            .byp_en  (idle),
            .wr_en0  (i_wr_en0),
            .wr_addr0(i_wr_addr0),
            .wr_data0(i_wr_data0),
            .wr_en1  (i_wr_en1),
            .wr_addr1(i_wr_addr1),
            .wr_data1(i_wr_data1),
            .rd_data (rd_data_a[k])
        );
    end
endmodule

// File: tb/tb_regfile_mp.sv
// Randomized and directed bench for regfile_mp (NUM_RD=4, BYPASS=1, ZERO_REG=1).
// Reference model: a plain array, a sweep flag and a sweep position.
module tb_regfile_mp;
    localparam int BD = 16;
    localparam int BA = 4;
    localparam int NR = 4;
    localparam int DEPTH = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              clr;
    logic              busy;
    logic              wr_en0, wr_en1;
    logic [BA-1:0]     wr_addr0, wr_addr1;
    logic [BD-1:0]     wr_data0, wr_data1;
    logic [NR*BA-1:0]  rd_addr;
    logic [NR*BD-1:0]  rd_data;

    int n_chk = 0;
    int n_err = 0;

    // reference state
    logic [BD-1:0] m [DEPTH];
    bit            mb;
    int            mc;

    regfile_mp #(.BW_DATA(BD), .BW_ADDR(BA), .NUM_RD(NR), .BYPASS(1), .ZERO_REG(1)) dut (
        .i_clk(clk), .i_rst(rst), .i_clr(clr), .o_busy(busy),
        .i_wr_en0(wr_en0), .i_wr_addr0(wr_addr0), .i_wr_data0(wr_data0),
        .i_wr_en1(wr_en1), .i_wr_addr1(wr_addr1), .i_wr_data1(wr_data1),
        .i_rd_addr(rd_addr), .o_rd_data(rd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [BD-1:0] exp_rd(input logic [BA-1:0] a);
        if (a == 0) return '0;
        if (!mb) begin
            if (wr_en1 && wr_addr1 == a) return wr_data1;
            if (wr_en0 && wr_addr0 == a) return wr_data0;
        end
        return m[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m[i] = '0;
        mb = 0;
        mc = 0;
    endtask

    task automatic model_edge();
        if (mb) begin
            m[mc] = '0;
            mc++;
            if (mc == DEPTH) begin mb = 0; mc = 0; end
        end else begin
            if (wr_en0 && wr_addr0 != 0) m[wr_addr0] = wr_data0;
            if (wr_en1 && wr_addr1 != 0) m[wr_addr1] = wr_data1;
            if (clr) begin mb = 1; mc = 0; end
        end
    endtask

    function automatic logic [BD-1:0] port(input int k);
        return rd_data[k*BD +: BD];
    endfunction

    task automatic set_rd(input int k, input logic [BA-1:0] a);
        rd_addr[k*BA +: BA] = a;
    endtask

    task automatic idle_in();
        clr = 0; wr_en0 = 0; wr_en1 = 0;
    endtask

    // called with inputs driven after a negedge: check, take the edge, return at next negedge
    task automatic step();
        #1;
        for (int k = 0; k < NR; k++) chk($sformatf("rd%0d", k), port(k), exp_rd(rd_addr[k*BA +: BA]));
        chk("busy", busy, mb);
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic write0(input logic [BA-1:0] a, input logic [BD-1:0] d);
        idle_in();
        wr_en0 = 1; wr_addr0 = a; wr_data0 = d;
        step();
    endtask

    task automatic fill();
        for (int i = 0; i < DEPTH; i++) write0(BA'(i), BD'(16'h1000 + i));
        idle_in();
    endtask

    // runs a sweep started by clr in the current cycle; stops early if rst_at hits
    task automatic sweep(input int wr_at, input int clr_at, input int rst_at, output int len);
        idle_in();
        clr = 1;
        step();
        len = 0;
        idle_in();
        for (int g = 0; g < 40; g++) begin
            #1;
            if (!busy) break;
            idle_in();
            set_rd(0, 2); set_rd(1, 12); set_rd(2, 7); set_rd(3, 5);
            if (len == wr_at) begin wr_en0 = 1; wr_addr0 = 7; wr_data0 = 16'hBEEF; end
            if (len == clr_at) clr = 1;
            if (len == 8) begin
                #1;
                chk("mid_e2", port(0), 16'h0000);
                chk("mid_e12", port(1), 16'h100C);
            end
            if (len == rst_at) begin
                rst = 1;
                #1;
                chk("rst_busy", busy, 0);
                for (int k = 0; k < NR; k++) chk("rst_rd", port(k), 0);
                model_reset();
                @(negedge clk);
                rst = 0;
                idle_in();
                return;
            end
            len++;
            step();
        end
        idle_in();
    endtask

    initial begin
        int len;
        rst = 1; rd_addr = '0; wr_addr0 = '0; wr_addr1 = '0; wr_data0 = '0; wr_data1 = '0;
        idle_in();
        model_reset();
        @(negedge clk); @(negedge clk);
        chk("reset_busy", busy, 0);
        for (int k = 0; k < NR; k++) chk("reset_rd", port(k), 0);
        rst = 0;
        @(negedge clk);

        // async reset mid-cycle after a write
        write0(3, 16'hA5A5);
        set_rd(0, 3); set_rd(1, 3); set_rd(2, 1); set_rd(3, 0);
        idle_in();
        #1 chk("pre_rst_a5", port(0), 16'hA5A5);
        #2 rst = 1;
        #1 chk("async_rst_rd", port(0), 0);
        chk("async_rst_busy", busy, 0);
        model_reset();
        @(negedge clk);
        rst = 0;

        // fill and read back, four addresses per cycle
        fill();
        for (int j = 0; j < 4; j++) begin
            for (int k = 0; k < NR; k++) set_rd(k, BA'(4 * j + k));
            #1;
            for (int k = 0; k < NR; k++)
                chk("fill_rd", port(k), (4 * j + k == 0) ? 16'h0 : 16'h1000 + 4 * j + k);
            step();
        end

        // collision with bypass: port 1 data visible in the same cycle and stored after the edge
        set_rd(0, 5); set_rd(1, 4); set_rd(2, 6); set_rd(3, 0);
        wr_en0 = 1; wr_addr0 = 5; wr_data0 = 16'h1111;
        wr_en1 = 1; wr_addr1 = 5; wr_data1 = 16'h2222;
        #1 chk("coll_byp", port(0), 16'h2222);
        step();
        idle_in();
        #1 chk("coll_stored", port(0), 16'h2222);
        // zero entry: write to 0 with bypass still reads 0
        wr_en1 = 1; wr_addr1 = 0; wr_data1 = 16'h7777;
        #1 chk("zero_byp", port(3), 0);
        step();

        // clear sweep length and mid-sweep contents
        fill();
        sweep(-1, -1, -1, len);
        chk("sweep_len", len, 16);
        for (int k = 0; k < NR; k++) set_rd(k, BA'(k + 5));
        #1 for (int k = 0; k < NR; k++) chk("post_sweep", port(k), 0);
        step();

        // writes and clr during sweep are ignored
        fill();
        sweep(3, 5, -1, len);
        chk("sweep2_len", len, 16);
        set_rd(0, 7);
        #1 chk("wr_in_sweep", port(0), 0);
        step();

        // clr with write in same idle cycle: write lands, then swept
        fill();
        wr_en0 = 1; wr_addr0 = 9; wr_data0 = 16'h4242;
        clr = 1;
        step();
        idle_in();
        set_rd(0, 9);
        len = 0;
        for (int g = 0; g < 40 && busy; g++) begin len++; step(); end
        chk("clr_wr_len", len, 16);
        #1 chk("clr_wr_rd", port(0), 0);

        // reset mid-sweep, then a write succeeds
        fill();
        sweep(-1, -1, 8, len);
        write0(9, 16'h1234);
        idle_in();
        set_rd(0, 9);
        #1 chk("after_rst_wr", port(0), 16'h1234);
        step();

        // random traffic against the model
        for (int n = 0; n < 600; n++) begin
            wr_en0   = ($urandom_range(0, 2) != 0);
            wr_en1   = ($urandom_range(0, 2) != 0);
            wr_addr0 = BA'($urandom);
            wr_addr1 = ($urandom_range(0, 3) == 0) ? wr_addr0 : BA'($urandom);
            wr_data0 = BD'($urandom);
            wr_data1 = BD'($urandom);
            clr      = ($urandom_range(0, 60) == 0);
            for (int k = 0; k < NR; k++)
                set_rd(k, ($urandom_range(0, 2) == 0) ? wr_addr1 : BA'($urandom));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
